vga_pixel_out: RTL and testbench
================================

VGA_PIXEL_OUT -- requirements
Module: vga_pixel_out

Interface
REQ-001 The module SHALL have parameter WIDTH, default 640, visible pixels per line.
REQ-002 The module SHALL have parameter HEIGHT, default 480, visible lines per frame.
REQ-003 The module SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-004 The module SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 The module SHALL have parameter LAT, default 2 (range 1..4), upstream pixel-return latency in pixel ticks.
REQ-006 The module SHALL use one clock and a synchronous, active-high reset: clk  input  1  system clock; reset  input  1  synchronous active-high reset.
REQ-007 pix_en  input  1  pixel tick; all timing state advances only on clk edges with pix_en=1.
REQ-008 req_x  output  10  requested column to upstream colour stage.
REQ-009 req_y  output  10  requested row to upstream colour stage.
REQ-010 req_valid  output  1  request is a visible pixel.
REQ-011 in_red, in_green, in_blue  input  8 each  pixel returned by upstream colour stage.
REQ-012 vga_r, vga_g, vga_b  output  8 each  registered pixel to DAC.
REQ-013 vga_hs, vga_vs  output  1 each  active-low syncs, registered.
REQ-014 vga_blank_n  output  1  high during visible pixels, registered.
REQ-015 frame_start  output  1  single-clk pulse at start of each frame's request phase.

Function
REQ-016 h_cnt SHALL count 0..HT-1 with HT=WIDTH+H_FP+H_SYNC+H_BP (800), incrementing on pix_en and wrapping to 0.
REQ-017 v_cnt SHALL count 0..VT-1 with VT=HEIGHT+V_FP+V_SYNC+V_BP (525), incrementing only on pix_en when h_cnt=HT-1, wrapping to 0 after VT-1.
REQ-018 req_x=h_cnt, req_y=v_cnt combinationally; req_valid=1 iff h_cnt<WIDTH and v_cnt<HEIGHT.
REQ-019 frame_start SHALL equal pix_en AND h_cnt=0 AND v_cnt=0 (combinational, one clk wide per frame).
REQ-020 Timing of counter position (h,v): hs_raw=0 iff WIDTH+H_FP<=h<WIDTH+H_FP+H_SYNC (656..751); vs_raw=0 iff HEIGHT+V_FP<=v<HEIGHT+V_FP+V_SYNC (490..491); act_raw=req_valid.
REQ-021 hs_raw, vs_raw, act_raw SHALL pass through a LAT-stage delay line that shifts only on pix_en.
REQ-022 Upstream contract: data for a request issued on pix_en tick N SHALL be present on in_* during pix_en tick N+LAT; module samples in_* only on that tick.
REQ-023 On each pix_en clk edge, output registers load: vga_hs/vga_vs/vga_blank_n from delay-line tail; vga_r/g/b = in_* if tail act=1, else 0.
REQ-024 Total latency: pixel requested on tick N appears on vga_* after tick N+LAT edge; syncs keep identical alignment to RGB.
REQ-025 Without pix_en all registers and counters SHALL hold; outputs static.
REQ-026 in_* values during blanking SHALL never reach vga_r/g/b.

Reset
REQ-027 reset SHALL take priority over pix_en.
REQ-028 During reset: h_cnt=0, v_cnt=0, delay line cleared to hs=1, vs=1, act=0.
REQ-029 Reset values: vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0; req_x=0, req_y=0, req_valid=1 (counters at origin).
REQ-030 Reset mid-frame SHALL restart at (0,0) on the first pix_en after release with no partial-line output; first visible pixel appears LAT ticks later.

Verification
REQ-031 Reset, pix_en every clk, in_*=8'hFF constant -> vga_blank_n rises LAT+1 edges after first tick, stays high 640 ticks, low 160 ticks per line.
REQ-032 Count one line -> vga_hs low exactly 96 ticks, falling 656 ticks after blank_n rise; HT=800 ticks between hs falls.
REQ-033 Count full frame -> vga_vs low 2 lines (1600 ticks), frame_start pulses once per 420000 ticks.
REQ-034 Model upstream as LAT=2 pipeline returning in_red=req_x[7:0], in_green=req_y[7:0] -> every visible vga pixel matches its coordinates; blanking shows 0.
REQ-035 pix_en every 2nd clk -> identical output sequence at half rate; outputs stable on non-enabled cycles.
REQ-036 Assert reset at (h=300,v=200) for 3 clks -> outputs at reset values next edge; after release first req is (0,0), frame_start pulses on first pix_en.

Source files
------------

// File: rtl/vga_pixel_out.sv
// VGA timing generator and output stage: issues pixel requests upstream, delays
// the sync/blank timing by the upstream latency and registers RGB and syncs together.
module vga_pixel_out #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int LAT    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] req_x,
    output logic [9:0] req_y,
    output logic       req_valid,
    input  logic [7:0] in_red,
    input  logic [7:0] in_green,
    input  logic [7:0] in_blue,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       frame_start
);

    localparam int HT = WIDTH + H_FP + H_SYNC + H_BP;
    localparam int VT = HEIGHT + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(HT - 1);
    localparam logic [9:0] V_LAST = 10'(VT - 1);
    localparam logic [9:0] H_VIS  = 10'(WIDTH);
    localparam logic [9:0] V_VIS  = 10'(HEIGHT);
    localparam logic [9:0] HS_BEG = 10'(WIDTH + H_FP);
    localparam logic [9:0] HS_END = 10'(WIDTH + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(HEIGHT + V_FP);
    localparam logic [9:0] VS_END = 10'(HEIGHT + V_FP + V_SYNC);

    logic [9:0]     h_cnt_q, h_cnt_d;
    logic [9:0]     v_cnt_q, v_cnt_d;
    logic [LAT-1:0] hs_dl_q, hs_dl_d;
    logic [LAT-1:0] vs_dl_q, vs_dl_d;
    logic [LAT-1:0] act_dl_q, act_dl_d;
    logic [7:0]     r_q, r_d, g_q, g_d, b_q, b_d;
    logic           hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic           hs_raw_s, vs_raw_s, act_raw_s;

    assign req_x       = h_cnt_q;
    assign req_y       = v_cnt_q;
    assign act_raw_s   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign req_valid   = act_raw_s;
    assign hs_raw_s    = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    assign vs_raw_s    = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    assign frame_start = pix_en && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;

    // Raster position: horizontal wraps each line, vertical steps at end of line.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 10'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
                v_cnt_d = v_cnt_q;
            end
        end else begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end
    end

    // Timing delay line matching the upstream colour latency; tail is element LAT-1.
    always_comb begin
        hs_dl_d  = hs_dl_q;
        vs_dl_d  = vs_dl_q;
        act_dl_d = act_dl_q;
        if (pix_en) begin
            hs_dl_d[0]  = hs_raw_s;
            vs_dl_d[0]  = vs_raw_s;
            act_dl_d[0] = act_raw_s;
            for (int i = 1; i < LAT; i++) begin
                hs_dl_d[i]  = hs_dl_q[i-1];
                vs_dl_d[i]  = vs_dl_q[i-1];
                act_dl_d[i] = act_dl_q[i-1];
            end
        end else begin
            hs_dl_d  = hs_dl_q;
            vs_dl_d  = vs_dl_q;
            act_dl_d = act_dl_q;
        end
    end

    // Output stage: colour is gated by the delayed active flag so blanking data never leaks.
    always_comb begin
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        if (pix_en) begin
            hs_d      = hs_dl_q[LAT-1];
            vs_d      = vs_dl_q[LAT-1];
            blank_n_d = act_dl_q[LAT-1];
            if (act_dl_q[LAT-1]) begin
                r_d = in_red;
                g_d = in_green;
                b_d = in_blue;
            end else begin
                r_d = 8'd0;
                g_d = 8'd0;
                b_d = 8'd0;
            end
        end else begin
            hs_d      = hs_q;
            vs_d      = vs_q;
            blank_n_d = blank_n_q;
        end
    end

    // State registers; reset wins over pix_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            hs_dl_q   <= {LAT{1'b1}};
            vs_dl_q   <= {LAT{1'b1}};
            act_dl_q  <= {LAT{1'b0}};
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            b_q       <= 8'd0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            hs_dl_q   <= hs_dl_d;
            vs_dl_q   <= vs_dl_d;
            act_dl_q  <= act_dl_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

endmodule

// File: tb/tb_vga_pixel_out.sv
// Bench for vga_pixel_out on a small raster: the model predicts every output from
// the count of pixel ticks since reset using plain modular arithmetic.
module tb_vga_pixel_out;

    localparam int W = 16, H = 8, HFP = 2, HSY = 3, HBP = 2, VFP = 1, VSY = 2, VBP = 1;
    localparam int LAT = 2;
    localparam int HT = W + HFP + HSY + HBP;   // 23
    localparam int VT = H + VFP + VSY + VBP;   // 12

    logic       clk = 1'b0;
    logic       reset, pix_en;
    logic [9:0] req_x, req_y;
    logic       req_valid;
    logic [7:0] in_red, in_green, in_blue;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, frame_start;

    int k;              // pixel ticks taken since the last reset edge
    int checks, failures;
    bit started, measure;
    int t_blank_rise, t_hs_fall1, t_hs_rise1, t_hs_fall2, t_vs_fall, t_vs_rise, t_fs1, t_fs2;
    logic prev_blank, prev_hs, prev_vs;

    always #5 clk = ~clk;

    vga_pixel_out #(
        .WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .req_x(req_x), .req_y(req_y), .req_valid(req_valid),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .frame_start(frame_start)
    );

    function automatic int hpos(input int m); return m % HT; endfunction
    function automatic int vpos(input int m); return (m / HT) % VT; endfunction
    function automatic bit vis(input int m); return (hpos(m) < W) && (vpos(m) < H); endfunction
    function automatic bit hs_of(input int m);
        return !((hpos(m) >= W + HFP) && (hpos(m) < W + HFP + HSY));
    endfunction
    function automatic bit vs_of(input int m);
        return !((vpos(m) >= H + VFP) && (vpos(m) < H + VFP + VSY));
    endfunction
    function automatic logic [23:0] pix(input int m);
        logic [7:0] r, g, b;
        r = 8'(hpos(m));
        g = 8'(vpos(m));
        b = 8'(hpos(m) + vpos(m)) ^ 8'hA5;
        return {r, g, b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s tick=%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    // One clock: apply inputs for the upcoming tick, then advance the model.
    task automatic step(input bit pe, input bit rst);
        pix_en = pe;
        reset  = rst;
        if (k >= LAT && vis(k - LAT)) {in_red, in_green, in_blue} = pix(k - LAT);
        else {in_red, in_green, in_blue} = 24'($urandom);
        @(posedge clk);
        if (rst) begin
            k = 0;
            started = 1'b1;
        end else if (pe) begin
            k = k + 1;
        end
        #1;
    endtask

    // Compare every output against the model each cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            int m;
            logic [2:0]  exp_sync;
            logic [23:0] exp_rgb;
            check("req", 64'({req_x, req_y, req_valid}),
                  64'({10'(hpos(k)), 10'(vpos(k)), vis(k)}));
            check("frame_start", 64'(frame_start), 64'(pix_en && ((k % (HT * VT)) == 0)));
            if (k <= LAT) begin
                exp_sync = 3'b110;
                exp_rgb  = 24'd0;
            end else begin
                m        = k - 1 - LAT;
                exp_sync = {hs_of(m), vs_of(m), vis(m)};
                exp_rgb  = vis(m) ? pix(m) : 24'd0;
            end
            check("sync_blank", 64'({vga_hs, vga_vs, vga_blank_n}), 64'(exp_sync));
            check("rgb", 64'({vga_r, vga_g, vga_b}), 64'(exp_rgb));
            if (measure && !reset) begin
                if (!prev_blank && vga_blank_n && t_blank_rise < 0) t_blank_rise = k;
                if (prev_hs && !vga_hs) begin
                    if (t_hs_fall1 < 0) t_hs_fall1 = k;
                    else if (t_hs_fall2 < 0) t_hs_fall2 = k;
                end
                if (!prev_hs && vga_hs && t_hs_fall1 >= 0 && t_hs_rise1 < 0) t_hs_rise1 = k;
                if (prev_vs && !vga_vs && t_vs_fall < 0) t_vs_fall = k;
                if (!prev_vs && vga_vs && t_vs_fall >= 0 && t_vs_rise < 0) t_vs_rise = k;
                if (frame_start) begin
                    if (t_fs1 < 0) t_fs1 = k;
                    else if (t_fs2 < 0) t_fs2 = k;
                end
            end
            prev_blank = vga_blank_n;
            prev_hs    = vga_hs;
            prev_vs    = vga_vs;
        end
    end

    initial begin
        int n;
        checks = 0; failures = 0; k = 0; started = 1'b0; measure = 1'b0;
        t_blank_rise = -1; t_hs_fall1 = -1; t_hs_rise1 = -1; t_hs_fall2 = -1;
        t_vs_fall = -1; t_vs_rise = -1; t_fs1 = -1; t_fs2 = -1;
        prev_blank = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
        reset = 1'b1; pix_en = 1'b0; {in_red, in_green, in_blue} = 24'd0;

        // Continuous pix_en from reset: measure edges against hand-computed values.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        measure = 1'b1;
        repeat (600) step(1'b1, 1'b0);
        measure = 1'b0;
        check("blank_rise", 64'(t_blank_rise), 64'd3);
        check("hs_fall1", 64'(t_hs_fall1), 64'd21);
        check("hs_rise1", 64'(t_hs_rise1), 64'd24);
        check("hs_fall2", 64'(t_hs_fall2), 64'd44);
        check("vs_fall", 64'(t_vs_fall), 64'd210);
        check("vs_rise", 64'(t_vs_rise), 64'd256);
        check("fs_first", 64'(t_fs1), 64'd0);
        check("fs_second", 64'(t_fs2), 64'd276);

        // Half-rate pixel ticks, then random gaps.
        repeat (800) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        repeat (800) step(1'($urandom_range(0, 3) != 0), 1'b0);

        // Mid-frame reset at (10,5), then restart with a short idle gap.
        n = 0;
        while (!(hpos(k) == 10 && vpos(k) == 5) && n < 3000) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("reach_mid_frame", 64'(hpos(k) == 10 && vpos(k) == 5), 64'd1);
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (400) step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
